// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between two byte-stream requesters, the arbiter and the UART transmitter pins.
// The master side is the environment (requesters plus UART); the slave side is the arbiter.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] uart_din;
    logic       uart_wr_en;
    logic       uart_wr_rdy;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output uart_wr_rdy,
        input  req0_ready, req1_ready,
        input  uart_din, uart_wr_en, grant, busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  uart_wr_rdy,
        output req0_ready, req1_ready,
        output uart_din, uart_wr_en, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between two byte streams.
// A grant is held until a byte marked last goes out or MAX_BURST bytes have been sent.
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    // Exit on the edge where the counter would reach BUSY_TIMEOUT: BUSY_TIMEOUT cycles in WAIT_BUSY.
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       grant_reg, grant_next;
    logic             rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             last_reg, last_next;
    logic [7:0]       din_reg, din_next;
    logic             wr_en_reg, wr_en_next;
    logic             busy_reg, busy_next;

    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] last_in;
    logic [7:0] data_in [2];
    logic       transfer;
    logic       sel;

    assign valid      = {bus.req1_valid, bus.req0_valid};
    assign last_in    = {bus.req1_last, bus.req0_last};
    assign data_in[0] = bus.req0_data;
    assign data_in[1] = bus.req1_data;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready[gi] = grant_reg[gi] & (state_reg == ARM) & bus.uart_wr_rdy;
    end

    assign transfer = |(valid & ready);
    assign sel      = grant_reg[1];

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.uart_din   = din_reg;
    assign bus.uart_wr_en = wr_en_reg;
    assign bus.grant      = grant_reg;
    assign bus.busy       = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'b00;
            rr_ptr_reg <= 1'b0;
            count_reg  <= '0;
            to_cnt_reg <= '0;
            last_reg   <= 1'b0;
            din_reg    <= 8'h00;
            wr_en_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            count_reg  <= count_next;
            to_cnt_reg <= to_cnt_next;
            last_reg   <= last_next;
            din_reg    <= din_next;
            wr_en_reg  <= wr_en_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        count_next  = count_reg;
        to_cnt_next = to_cnt_reg;
        last_next   = last_reg;
        din_next    = din_reg;
        wr_en_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (|valid) begin
                    if (valid[rr_ptr_reg]) begin
                        grant_next = rr_ptr_reg ? 2'b10 : 2'b01;
                    end else begin
                        grant_next = rr_ptr_reg ? 2'b01 : 2'b10;
                    end
                    state_next = ARM;
                end
            end
            ARM: begin
                // Only the owner can transfer; the other requester waits out the packet.
                if (transfer) begin
                    din_next   = data_in[sel];
                    last_next  = last_in[sel];
                    wr_en_next = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.uart_wr_rdy || (to_cnt_reg == TO_LAST)) begin
                    to_cnt_next = '0;
                    state_next  = WAIT_DONE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.uart_wr_rdy) begin
                    if (last_reg || (count_reg == MAX_CNT)) begin
                        // Pointer moves to the requester that did not own this grant.
                        rr_ptr_next = grant_reg[0];
                        grant_next  = 2'b00;
                        count_next  = '0;
                        state_next  = IDLE;
                    end else begin
                        state_next = ARM;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART ready/busy model and queue-fed requesters.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if ifc ();

    uart_tx_arbiter #(.MAX_BURST(4), .BUSY_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [9:0] strobe_log [$];
    bit hold0 = 1'b0;

    // UART model: rdy drops on the edge that samples wr_en and stays low busy_len cycles.
    bit   model_drop = 1'b1;
    bit   force_low  = 1'b0;
    int   busy_len   = 10;
    int   bcnt;
    logic rdy_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_m <= 1'b1;
            bcnt  <= 0;
        end else if (ifc.uart_wr_en && model_drop) begin
            rdy_m <= 1'b0;
            bcnt  <= busy_len;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) rdy_m <= 1'b1;
        end
    end
    assign ifc.uart_wr_rdy = rdy_m & ~force_low;

    always @(negedge clk) begin
        if (!rst && ifc.uart_wr_en) begin
            strobe_log.push_back({ifc.grant, ifc.uart_din});
            $display("strobe grant=%b din=%02h", ifc.grant, ifc.uart_din);
        end
    end

    initial begin
        bit fire;
        ifc.req0_valid = 1'b0;
        ifc.req0_data  = 8'h00;
        ifc.req0_last  = 1'b0;
        forever begin
            @(negedge clk);
            fire = ifc.req0_valid && ifc.req0_ready;
            @(posedge clk);
            #1;
            if (fire && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0 && !hold0) begin
                ifc.req0_valid = 1'b1;
                {ifc.req0_last, ifc.req0_data} = q0[0];
            end else begin
                ifc.req0_valid = 1'b0;
            end
        end
    end

    initial begin
        bit fire;
        ifc.req1_valid = 1'b0;
        ifc.req1_data  = 8'h00;
        ifc.req1_last  = 1'b0;
        forever begin
            @(negedge clk);
            fire = ifc.req1_valid && ifc.req1_ready;
            @(posedge clk);
            #1;
            if (fire && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                ifc.req1_valid = 1'b1;
                {ifc.req1_last, ifc.req1_data} = q1[0];
            end else begin
                ifc.req1_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !ifc.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic check_log(input string tag, input int n,
                             input logic [9:0] e0 = 0, input logic [9:0] e1 = 0,
                             input logic [9:0] e2 = 0, input logic [9:0] e3 = 0,
                             input logic [9:0] e4 = 0, input logic [9:0] e5 = 0,
                             input logic [9:0] e6 = 0, input logic [9:0] e7 = 0);
        logic [9:0] e [8];
        logic [31:0] obs;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        chk({tag, "_count"}, 32'(strobe_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            obs = (i < strobe_log.size()) ? 32'(strobe_log[i]) : 32'hDEAD;
            chk($sformatf("%s_%0d", tag, i), obs, 32'(e[i]));
        end
        strobe_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int k;
        bit ok;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_din", 32'(ifc.uart_din), 32'h00);
        chk("rst_wr_en", 32'(ifc.uart_wr_en), 32'd0);
        chk("rst_grant", 32'(ifc.grant), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_ready0", 32'(ifc.req0_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single packet from req0
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        wait_done("single");
        check_log("single", 3, 10'h141, 10'h142, 10'h143);
        chk("single_grant_end", 32'(ifc.grant), 32'd0);
        chk("single_busy_end", 32'(ifc.busy), 32'd0);

        // Contention from reset: req0 first, then req1, then pointer back to req0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        q0.push_back({1'b0, 8'h10});
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h55});
        rst = 1'b0;
        wait_done("contend");
        check_log("contend", 3, 10'h110, 10'h111, 10'h255);
        q0.push_back({1'b1, 8'h20});
        q1.push_back({1'b1, 8'h66});
        wait_done("contend2");
        check_log("contend2", 2, 10'h120, 10'h266);

        // Burst cap of 4 on a 6-byte req1 packet while req0 waits
        for (int i = 0; i < 6; i++) q1.push_back({(i == 5), 8'(8'h60 + i)});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.grant == 2'b10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("burst_grant1", 32'(ok), 32'd1);
        q0.push_back({1'b0, 8'h30});
        q0.push_back({1'b1, 8'h31});
        wait_done("burst");
        check_log("burst", 8, 10'h260, 10'h261, 10'h262, 10'h263,
                  10'h130, 10'h131, 10'h264, 10'h265);

        // Stalled UART: no ready and no strobe while rdy is low
        force_low = 1'b1;
        q0.push_back({1'b1, 8'h77});
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.req0_ready || ifc.uart_wr_en) bad++;
        end
        chk("stall_no_ready", 32'(bad), 32'd0);
        chk("stall_grant", 32'(ifc.grant), 32'd1);
        @(posedge clk);
        #2;
        model_drop = 1'b0;
        force_low  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.uart_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout_strobe", 32'(ok), 32'd1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (!ifc.busy) break;
        end
        chk("timeout_cycles", 32'(k), 32'd5);
        check_log("timeout", 1, 10'h177);
        model_drop = 1'b1;

        // Packet lock: req0 pauses mid-packet, req1 must not get in
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b1, 8'h02});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (strobe_log.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("lock_first", 32'(ok), 32'd1);
        hold0 = 1'b1;
        q1.push_back({1'b1, 8'h99});
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.grant != 2'b01 || ifc.req1_ready) bad++;
        end
        chk("lock_hold", 32'(bad), 32'd0);
        hold0 = 1'b0;
        wait_done("lock");
        check_log("lock", 3, 10'h101, 10'h102, 10'h299);

        // Reset mid-packet during WAIT_DONE, with the pointer left on req1
        q0.push_back({1'b1, 8'hA0});
        wait_done("pre_rst");
        check_log("pre_rst", 1, 10'h1A0);
        q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b1, 8'hA2});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.uart_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstmid_strobe", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        chk("rstmid_busy_before", 32'(ifc.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_wr_en", 32'(ifc.uart_wr_en), 32'd0);
        chk("rstmid_grant", 32'(ifc.grant), 32'd0);
        chk("rstmid_busy", 32'(ifc.busy), 32'd0);
        chk("rstmid_din", 32'(ifc.uart_din), 32'h00);
        q0.delete();
        q1.delete();
        strobe_log.delete();
        repeat (2) @(negedge clk);
        q0.push_back({1'b1, 8'hB0});
        q1.push_back({1'b1, 8'hB1});
        rst = 1'b0;
        wait_done("post_rst");
        check_log("post_rst", 2, 10'h1B0, 10'h2B1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
